// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the ALU-control pipe.
//   - opcode / opext constants (low 4 bits of each field)
//   - ALU function codes (4-bit, zero-extended to CTL_W by users)
//   - FSM state type for the handshake pipe
package alu_ctrl_pkg;

    // I-type opcodes
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_COMPI = 4'b1011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_MOVR  = 4'b0110;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // R-type opext values, plus the shift selector under OP_SHIFT
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_COMP = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_LSH  = 4'b0100;

    // ALU function codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_COMP = 4'b0101;
    localparam logic [3:0] ALU_MOV  = 4'b0110;
    localparam logic [3:0] ALU_LSH  = 4'b0111;
    localparam logic [3:0] ALU_LSHI = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_MOVR = 4'b1010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_WAIT = 2'd1,
        OUT     = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational {opcode, opext} -> {alucont, mc_op, illegal}.
//   opcode, opext : instruction fields (OP_W bits; bits above [3:0] must be 0)
//   alucont       : ALU function code, zero-extended to CTL_W
//   mc_op         : op is a multi-cycle shift (lsh / lshi)
//   illegal       : encoding not recognised; alucont forced to add (0)
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int CTL_W = 4
) (
    input  logic [OP_W-1:0]  opcode,
    input  logic [OP_W-1:0]  opext,
    output logic [CTL_W-1:0] alucont,
    output logic             mc_op,
    output logic             illegal
);

    logic       upper_nz;
    logic [3:0] code;
    logic       bad;

    // Any set bit above the 4-bit encoding space makes the op illegal.
    always_comb begin
        upper_nz = 1'b0;
        for (int i = 4; i < OP_W; i++)
            upper_nz = upper_nz | opcode[i] | opext[i];
    end

    always_comb begin
        code = ALU_ADD;
        bad  = 1'b0;
        case (opcode[3:0])
            OP_ADDI:  code = ALU_ADD;
            OP_SUBI:  code = ALU_SUB;
            OP_ANDI:  code = ALU_AND;
            OP_XORI:  code = ALU_XOR;
            OP_ORI:   code = ALU_OR;
            OP_COMPI: code = ALU_COMP;
            OP_MOVI:  code = ALU_MOV;
            OP_MOVR:  code = ALU_MOVR;
            OP_LUI:   code = ALU_LUI;
            OP_SHIFT: code = (opext[3:0] == EXT_LSH) ? ALU_LSH : ALU_LSHI;
            OP_RTYPE: begin
                case (opext[3:0])
                    EXT_ADD:  code = ALU_ADD;
                    EXT_SUB:  code = ALU_SUB;
                    EXT_AND:  code = ALU_AND;
                    EXT_XOR:  code = ALU_XOR;
                    EXT_OR:   code = ALU_OR;
                    EXT_COMP: code = ALU_COMP;
                    EXT_MOV:  code = ALU_MOV;
                    default:  bad  = 1'b1;
                endcase
            end
            default:  bad = 1'b1;
        endcase
        if (upper_nz)
            bad = 1'b1;
        if (bad)
            code = ALU_ADD;
    end

    assign alucont = CTL_W'(code);
    assign illegal = bad;
    assign mc_op   = !bad && (code == ALU_LSH || code == ALU_LSHI);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered, valid/ready ALU-control stage.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : decode-side handshake carrying opcode, opext
//   out_valid / out_ready : execute-side handshake carrying alucont, mc_op, illegal
//   busy                  : FSM not idle
//   illegal_cnt           : saturating count of accepted illegal ops
// Shift ops are held in MC_WAIT so out_valid appears MC_CYCLES after accept.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W      = 4,
    parameter int CTL_W     = 4,
    parameter int MC_CYCLES = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic [OP_W-1:0]  opext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTL_W-1:0] alucont,
    output logic             mc_op,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int MCW     = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;
    localparam int MC_LOAD = (MC_CYCLES > 1) ? MC_CYCLES - 2 : 0;

    state_t            state, next_state;
    logic [MCW-1:0]    mc_cnt;
    logic [CTL_W-1:0]  dec_alucont;
    logic              dec_mc, dec_illegal;
    logic              accept;

    alu_ctrl_decode #(.OP_W(OP_W), .CTL_W(CTL_W)) u_decode (
        .opcode  (opcode),
        .opext   (opext),
        .alucont (dec_alucont),
        .mc_op   (dec_mc),
        .illegal (dec_illegal)
    );

    assign in_ready  = !reset && (state == IDLE || (state == OUT && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE, OUT: begin
                if (accept)
                    next_state = (dec_mc && MC_CYCLES > 1) ? MC_WAIT : OUT;
                else if (state == OUT && out_ready)
                    next_state = IDLE;
            end
            MC_WAIT: if (mc_cnt == '0) next_state = OUT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mc_cnt      <= '0;
            alucont     <= '0;
            mc_op       <= 1'b0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                alucont <= dec_alucont;
                mc_op   <= dec_mc;
                illegal <= dec_illegal;
                mc_cnt  <= MCW'(MC_LOAD);
                if (dec_illegal && !(&illegal_cnt))
                    illegal_cnt <= illegal_cnt + 1'b1;
            end else if (state == OUT && out_ready) begin
                // Drain to IDLE: outputs return to zero.
                alucont <= '0;
                mc_op   <= 1'b0;
                illegal <= 1'b0;
            end
            if (state == MC_WAIT && mc_cnt != '0)
                mc_cnt <= mc_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic [3:0] opcode, opext;
    logic       out_valid, out_ready;
    logic [3:0] alucont;
    logic       mc_op, illegal, busy;
    logic [1:0] illegal_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_ctrl_pipe #(.OP_W(4), .CTL_W(4), .MC_CYCLES(3), .CNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .opext       (opext),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alucont     (alucont),
        .mc_op       (mc_op),
        .illegal     (illegal),
        .busy        (busy),
        .illegal_cnt (illegal_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock, land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] a,
                           input logic m, input logic il);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".alucont"},   32'(alucont),   32'(a));
        chk({tag, ".mc_op"},     32'(mc_op),     32'(m));
        chk({tag, ".illegal"},   32'(illegal),   32'(il));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; opext = '0;
        tick(); tick();

        // reset state
        chk("rst.in_ready", 32'(in_ready), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.cnt", 32'(illegal_cnt), 0);
        chk_out("rst", 0, 4'h0, 0, 0);
        reset = 1'b0;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 1);

        // single addi, latency 1, then back to IDLE
        opcode = 4'b0101; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_out("addi", 1, 4'b0000, 0, 0);
        chk("addi.busy", 32'(busy), 1);
        tick();
        chk("addi.idle_valid", 32'(out_valid), 0);
        chk("addi.idle_busy", 32'(busy), 0);

        // back-to-back stream, one per cycle
        opcode = 4'b1001; in_valid = 1'b1;
        tick();
        chk_out("subi", 1, 4'b0001, 0, 0);
        opcode = 4'b0001; #1;
        chk("stream.in_ready0", 32'(in_ready), 1);
        tick();
        chk_out("andi", 1, 4'b0010, 0, 0);
        opcode = 4'b0011; #1;
        chk("stream.in_ready1", 32'(in_ready), 1);
        tick();
        chk_out("xori", 1, 4'b0011, 0, 0);
        in_valid = 1'b0;
        tick();
        chk("stream.drain", 32'(out_valid), 0);

        // lsh with MC_CYCLES=3
        opcode = 4'b1000; opext = 4'b0100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lsh.c1.in_ready", 32'(in_ready), 0);
        chk("lsh.c1.out_valid", 32'(out_valid), 0);
        chk("lsh.c1.busy", 32'(busy), 1);
        tick();
        chk("lsh.c2.in_ready", 32'(in_ready), 0);
        chk("lsh.c2.out_valid", 32'(out_valid), 0);
        tick();
        chk_out("lsh.c3", 1, 4'b0111, 1, 0);
        tick();
        chk_out("lsh.idle", 0, 4'b0000, 0, 0);

        // lshi
        opext = 4'b0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lshi.c1.out_valid", 32'(out_valid), 0);
        tick();
        chk("lshi.c2.out_valid", 32'(out_valid), 0);
        tick();
        chk_out("lshi.c3", 1, 4'b1000, 1, 0);
        tick();

        // backpressure: lui held for 4 cycles
        opcode = 4'b1111; opext = 4'b0000; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_out("lui.stall", 1, 4'b1001, 0, 0);
            chk("lui.stall.in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1; opcode = 4'b0010; #1;
        chk("release.in_ready", 32'(in_ready), 1);
        tick();
        chk_out("ori", 1, 4'b0100, 0, 0);

        // illegal encodings back-to-back, counter saturates at 3
        opcode = 4'b0000; opext = 4'b1111;
        tick();
        chk_out("ill.rtype", 1, 4'b0000, 0, 1);
        chk("ill.cnt1", 32'(illegal_cnt), 1);
        opcode = 4'b0111; opext = 4'b0000;
        tick();
        chk_out("ill.op0111", 1, 4'b0000, 0, 1);
        chk("ill.cnt2", 32'(illegal_cnt), 2);
        opcode = 4'b0100;
        tick();
        chk("ill.cnt3", 32'(illegal_cnt), 3);
        opcode = 4'b1010;
        tick();
        chk("ill.cnt_sat4", 32'(illegal_cnt), 3);
        opcode = 4'b1100;
        tick();
        chk("ill.cnt_sat5", 32'(illegal_cnt), 3);
        chk("ill.flag5", 32'(illegal), 1);

        // legal R-type and movr after illegals
        opcode = 4'b0000; opext = 4'b0011;
        tick();
        chk_out("r_xor", 1, 4'b0011, 0, 0);
        chk("r_xor.cnt", 32'(illegal_cnt), 3);
        opcode = 4'b0110; opext = 4'b0000;
        tick();
        chk_out("movr", 1, 4'b1010, 0, 0);
        in_valid = 1'b0;
        tick();

        // reset while in MC_WAIT aborts the op
        opcode = 4'b1000; opext = 4'b0100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("abort.busy_before", 32'(busy), 1);
        reset = 1'b1;
        tick();
        chk("abort.out_valid", 32'(out_valid), 0);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.cnt", 32'(illegal_cnt), 0);
        chk("abort.in_ready_rst", 32'(in_ready), 0);
        reset = 1'b0; #1;
        chk("abort.in_ready", 32'(in_ready), 1);
        tick();
        chk("abort.no_out1", 32'(out_valid), 0);
        tick();
        chk("abort.no_out2", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
